// File: rtl/ext_wb_arbiter.sv
// Two-master round-robin arbiter for the external classic Wishbone slave bus.
// Master 0 is the CPU ext port, master 1 the loader/DMA engine. The grant is
// held for one whole transaction and the bus returns to IDLE (s_stb low) for
// at least one cycle between transactions. A watchdog ends transactions that
// are never acknowledged and reports an error to the owning master.
module ext_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255  // max BUSY cycles before error; 0 disables
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    input  logic          m0_we,
    input  logic          m0_stb,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    input  logic          m1_we,
    input  logic          m1_stb,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    output logic          s_we,
    output logic          s_stb,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack,
    output logic          o_owner,
    output logic          o_busy
);

    // Counter wide enough to hold TIMEOUT; it saturates at all-ones.
    localparam int             WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             WDOG_EN   = (TIMEOUT > 0);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WDW-1:0] WDOG_MAX  = {WDW{1'b1}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            we_q, we_d;

    logic            busy;
    logic            own_stb;
    logic            tmo;
    logic            grant;

    // Bus-side view of the current transaction; reset drops s_stb at once
    // because state_q clears asynchronously.
    always_comb begin
        busy     = (state_q == BUSY);
        own_stb  = owner_q ? m1_stb : m0_stb;
        tmo      = busy && WDOG_EN && (wdog_q == WDOG_LAST) && own_stb && !s_ack;
        s_stb    = busy && own_stb;
        s_adr    = adr_q;
        s_dat_w  = dat_q;
        s_we     = we_q;
        m0_ack   = busy && s_ack && !owner_q;
        m1_ack   = busy && s_ack && owner_q;
        m0_err   = tmo && !owner_q;
        m1_err   = tmo && owner_q;
        m0_dat_r = (busy && !owner_q) ? s_dat_r : '0;
        m1_dat_r = (busy && owner_q) ? s_dat_r : '0;
        o_owner  = owner_q;
        o_busy   = busy;
    end

    // Next-state: arbitrate in IDLE, then finish on ack, abort or timeout.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        wdog_d  = wdog_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        grant   = (m0_stb && m1_stb) ? prio_q : m1_stb;
        case (state_q)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    state_d = BUSY;
                    owner_d = grant;
                    wdog_d  = '0;
                    adr_d   = grant ? m1_adr   : m0_adr;
                    dat_d   = grant ? m1_dat_w : m0_dat_w;
                    we_d    = grant ? m1_we    : m0_we;
                end
            end
            BUSY: begin
                if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (s_ack) begin
                    state_d = IDLE;
                    prio_d  = !owner_q;
                end else if (!own_stb) begin
                    // Owner withdrew: no ack/err, fairness unchanged.
                    state_d = IDLE;
                end else if (tmo) begin
                    state_d = IDLE;
                    prio_d  = !owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            wdog_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            wdog_q  <= wdog_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_ext_wb_arbiter.sv
// Directed bench for ext_wb_arbiter (TIMEOUT=8). Inputs change 1 time unit
// after each rising edge; outputs are sampled 1 time unit later.
module tb_ext_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic        m0_we, m0_stb, m0_ack, m0_err;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic        m1_we, m1_stb, m1_ack, m1_err;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_we, s_stb, s_ack;
    logic        o_owner, o_busy;

    int errors = 0;
    int checks = 0;
    logic exp_own;

    ext_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_we(m0_we), .m0_stb(m0_stb),
        .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_we(m1_we), .m1_stb(m1_stb),
        .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_we(s_we), .s_stb(s_stb),
        .s_dat_r(s_dat_r), .s_ack(s_ack),
        .o_owner(o_owner), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat_w = '0; m0_we = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat_w = '0; m1_we = 1'b0; m1_stb = 1'b0;
        s_dat_r = '0; s_ack = 1'b0;
        clk1(); clk1();
        #1;
        chk("rst_stb", 32'(s_stb), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_owner", 32'(o_owner), 32'd0);
        chk("rst_adr", s_adr, 32'd0);
        chk("rst_datr", m0_dat_r, 32'd0);

        // 1. m0 single read, slave acks on the 3rd BUSY cycle
        clk1();
        rst = 1'b0;
        m0_adr = 32'h0070_0010; m0_stb = 1'b1;
        #1 chk("t1_idle_stb", 32'(s_stb), 32'd0);
        clk1();
        #1 chk("t1_stb", 32'(s_stb), 32'd1);
        chk("t1_adr", s_adr, 32'h0070_0010);
        chk("t1_we", 32'(s_we), 32'd0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        clk1();
        #1 chk("t1_noack", 32'(m0_ack), 32'd0);
        clk1();
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        #1 chk("t1_ack", 32'(m0_ack), 32'd1);
        chk("t1_datr", m0_dat_r, 32'hDEAD_BEEF);
        chk("t1_m1ack", 32'(m1_ack), 32'd0);
        chk("t1_m1datr", m1_dat_r, 32'd0);
        clk1();
        s_ack = 1'b0; m0_stb = 1'b0;
        #1 chk("t1_gap_stb", 32'(s_stb), 32'd0);
        chk("t1_gap_ack", 32'(m0_ack), 32'd0);
        chk("t1_gap_busy", 32'(o_busy), 32'd0);

        // 2. simultaneous requests right after reset: m0 first, then m1
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        m0_adr = 32'h0000_0100; m0_stb = 1'b1;
        m1_adr = 32'h0000_0200; m1_dat_w = 32'h1234_5678; m1_we = 1'b1; m1_stb = 1'b1;
        clk1();
        s_ack = 1'b1; s_dat_r = 32'hAAAA_0001;
        #1 chk("t2_own0", 32'(o_owner), 32'd0);
        chk("t2_adr0", s_adr, 32'h0000_0100);
        chk("t2_ack0", 32'(m0_ack), 32'd1);
        chk("t2_m1ack0", 32'(m1_ack), 32'd0);
        clk1();
        s_ack = 1'b0; m0_stb = 1'b0;
        #1 chk("t2_gap_stb", 32'(s_stb), 32'd0);
        clk1();
        s_ack = 1'b1; s_dat_r = 32'hBBBB_0002;
        #1 chk("t2_own1", 32'(o_owner), 32'd1);
        chk("t2_adr1", s_adr, 32'h0000_0200);
        chk("t2_dat1", s_dat_w, 32'h1234_5678);
        chk("t2_we1", 32'(s_we), 32'd1);
        chk("t2_ack1", 32'(m1_ack), 32'd1);
        chk("t2_m0ack1", 32'(m0_ack), 32'd0);
        chk("t2_m0datr", m0_dat_r, 32'd0);
        chk("t2_m1datr", m1_dat_r, 32'hBBBB_0002);
        clk1();
        s_ack = 1'b0; m1_stb = 1'b0;

        // 3. both hold stb for 6 transactions, ack on the 2nd BUSY cycle
        m0_stb = 1'b1; m1_stb = 1'b1;
        exp_own = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t3_idle_stb", 32'(s_stb), 32'd0);
            clk1();
            #1 chk("t3_owner", 32'(o_owner), 32'(exp_own));
            chk("t3_stb", 32'(s_stb), 32'd1);
            clk1();
            s_ack = 1'b1;
            #1 chk("t3_ack_own", 32'(exp_own ? m1_ack : m0_ack), 32'd1);
            chk("t3_ack_oth", 32'(exp_own ? m0_ack : m1_ack), 32'd0);
            clk1();
            s_ack = 1'b0;
            exp_own = ~exp_own;
        end
        m0_stb = 1'b0; m1_stb = 1'b0;

        // 4. m1 write never acked; m0 waits; error on 8th BUSY cycle
        clk1();
        m1_adr = 32'h0000_0300; m1_we = 1'b1; m1_stb = 1'b1;
        clk1();
        m0_adr = 32'h0000_0400; m0_we = 1'b1; m0_dat_w = 32'h5555_AAAA; m0_stb = 1'b1;
        #1 chk("t4_owner", 32'(o_owner), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            #1 chk("t4_m1err", 32'(m1_err), (k == 8) ? 32'd1 : 32'd0);
            chk("t4_m1ack", 32'(m1_ack), 32'd0);
            chk("t4_m0err", 32'(m0_err), 32'd0);
            clk1();
        end
        m1_stb = 1'b0;
        #1 chk("t4_after_stb", 32'(s_stb), 32'd0);
        chk("t4_after_err", 32'(m1_err), 32'd0);
        clk1();

        // 5. m0 now owner; ack coincides with the timeout cycle
        #1 chk("t5_owner", 32'(o_owner), 32'd0);
        chk("t5_adr", s_adr, 32'h0000_0400);
        for (int k = 1; k < 8; k++) begin
            #1 chk("t5_early_err", 32'(m0_err), 32'd0);
            clk1();
        end
        s_ack = 1'b1;
        #1 chk("t5_ack", 32'(m0_ack), 32'd1);
        chk("t5_err", 32'(m0_err), 32'd0);
        clk1();
        s_ack = 1'b0; m0_stb = 1'b0;
        #1 chk("t5_idle", 32'(o_busy), 32'd0);

        // 6. reset on the 2nd BUSY cycle
        m0_adr = 32'h0000_0500; m0_we = 1'b0; m0_stb = 1'b1;
        clk1();
        clk1();
        #1 chk("t6_pre_stb", 32'(s_stb), 32'd1);
        rst = 1'b1;
        #1 chk("t6_stb", 32'(s_stb), 32'd0);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_ack", 32'(m0_ack), 32'd0);
        chk("t6_err", 32'(m0_err), 32'd0);
        clk1();
        rst = 1'b0;
        clk1();
        s_ack = 1'b1; s_dat_r = 32'hCAFE_F00D;
        #1 chk("t6_serve_own", 32'(o_owner), 32'd0);
        chk("t6_serve_ack", 32'(m0_ack), 32'd1);
        chk("t6_serve_dat", m0_dat_r, 32'hCAFE_F00D);
        clk1();
        s_ack = 1'b0; m0_stb = 1'b0;

        // 7. m1 owner aborts; prio stays with m1
        m0_stb = 1'b1; m1_stb = 1'b1;
        clk1();
        #1 chk("t7_owner", 32'(o_owner), 32'd1);
        m1_stb = 1'b0;
        #1 chk("t7_stb", 32'(s_stb), 32'd0);
        chk("t7_ack", 32'(m1_ack), 32'd0);
        chk("t7_err", 32'(m1_err), 32'd0);
        clk1();
        m1_stb = 1'b1;
        #1 chk("t7_idle", 32'(o_busy), 32'd0);
        clk1();
        #1 chk("t7_prio_kept", 32'(o_owner), 32'd1);
        s_ack = 1'b1;
        #1 chk("t7_ack2", 32'(m1_ack), 32'd1);
        clk1();
        s_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
